// File: rtl/hazard_controller.sv
// Pipeline hazard controller: E/M scoreboard driving operand forwarding selects,
// load-use stalls, branch flushes and a saturating load-use stall counter.
module hazard_controller #(
    parameter int RA_W  = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_valid,
    input  logic [RA_W-1:0]  dec_rs1,
    input  logic [RA_W-1:0]  dec_rs2,
    input  logic             dec_rs1_used,
    input  logic             dec_rs2_used,
    input  logic [RA_W-1:0]  dec_rd,
    input  logic             dec_wr,
    input  logic             dec_load,
    input  logic             branch_taken,
    output logic             stall_fetch,
    output logic             stall_decode,
    output logic             flush_fetchdec,
    output logic             flush_decex,
    output logic [1:0]       fwdA_sel,
    output logic [1:0]       fwdB_sel,
    output logic [CNT_W-1:0] stall_count
);

    typedef struct packed {
        logic            v;
        logic            wr;
        logic            ld;
        logic [RA_W-1:0] rd;
    } sb_entry_t;

    localparam logic [1:0] SEL_RF  = 2'b00;
    localparam logic [1:0] SEL_ALU = 2'b01;
    localparam logic [1:0] SEL_WB  = 2'b10;

    // The Writeback entry is not kept: the register file writes before it
    // reads, so an instruction in W never needs forwarding.
    sb_entry_t       ex_q;
    logic            mem_v;
    logic            mem_wr;
    logic [RA_W-1:0] mem_rd;

    logic       rs1_ex_hit, rs2_ex_hit;
    logic       rs1_mem_hit, rs2_mem_hit;
    logic       load_use;
    logic       stall;
    logic       issue;
    logic [1:0] fwd_a_d, fwd_b_d;

    function automatic logic src_hit(
        input logic            used,
        input logic [RA_W-1:0] src,
        input logic            v,
        input logic            wr,
        input logic [RA_W-1:0] rd
    );
        return used & v & wr & (rd == src);
    endfunction

    always_comb begin
        rs1_ex_hit  = src_hit(dec_rs1_used, dec_rs1, ex_q.v, ex_q.wr, ex_q.rd);
        rs2_ex_hit  = src_hit(dec_rs2_used, dec_rs2, ex_q.v, ex_q.wr, ex_q.rd);
        rs1_mem_hit = src_hit(dec_rs1_used, dec_rs1, mem_v, mem_wr, mem_rd);
        rs2_mem_hit = src_hit(dec_rs2_used, dec_rs2, mem_v, mem_wr, mem_rd);

        load_use = dec_valid & ex_q.ld & (rs1_ex_hit | rs2_ex_hit);
        stall    = load_use & ~branch_taken;
        issue    = dec_valid & ~load_use & ~branch_taken;

        stall_fetch    = stall;
        stall_decode   = stall;
        flush_fetchdec = branch_taken;
        flush_decex    = load_use | branch_taken;

        // Youngest producer wins: an ALU result in E beats anything in M.
        fwd_a_d = SEL_RF;
        fwd_b_d = SEL_RF;
        if (issue) begin
            if (rs1_ex_hit && !ex_q.ld) fwd_a_d = SEL_ALU;
            else if (rs1_mem_hit)       fwd_a_d = SEL_WB;
            if (rs2_ex_hit && !ex_q.ld) fwd_b_d = SEL_ALU;
            else if (rs2_mem_hit)       fwd_b_d = SEL_WB;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_q        <= '0;
            mem_v       <= 1'b0;
            mem_wr      <= 1'b0;
            mem_rd      <= '0;
            fwdA_sel    <= SEL_RF;
            fwdB_sel    <= SEL_RF;
            stall_count <= '0;
        end else begin
            mem_v  <= ex_q.v;
            mem_wr <= ex_q.wr;
            mem_rd <= ex_q.rd;
            if (issue) begin
                ex_q.v  <= 1'b1;
                ex_q.wr <= dec_wr;
                ex_q.ld <= dec_load;
                ex_q.rd <= dec_rd;
            end else begin
                ex_q <= '0;
            end
            fwdA_sel <= fwd_a_d;
            fwdB_sel <= fwd_b_d;
            if (stall && (stall_count != '1))
                stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_controller.sv
// Bench for hazard_controller: directed hazard scenarios plus random traffic,
// checked against an instruction-history reference model.
module tb_hazard_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic       dec_valid;
    logic [3:0] dec_rs1, dec_rs2, dec_rd;
    logic       dec_rs1_used, dec_rs2_used;
    logic       dec_wr, dec_load, branch_taken;
    logic       stall_fetch, stall_decode, flush_fetchdec, flush_decex;
    logic [1:0] fwdA_sel, fwdB_sel;
    logic [2:0] stall_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    hazard_controller #(.RA_W(4), .CNT_W(3)) dut (
        .clk            (clk),
        .rst            (rst),
        .dec_valid      (dec_valid),
        .dec_rs1        (dec_rs1),
        .dec_rs2        (dec_rs2),
        .dec_rs1_used   (dec_rs1_used),
        .dec_rs2_used   (dec_rs2_used),
        .dec_rd         (dec_rd),
        .dec_wr         (dec_wr),
        .dec_load       (dec_load),
        .branch_taken   (branch_taken),
        .stall_fetch    (stall_fetch),
        .stall_decode   (stall_decode),
        .flush_fetchdec (flush_fetchdec),
        .flush_decex    (flush_decex),
        .fwdA_sel       (fwdA_sel),
        .fwdB_sel       (fwdB_sel),
        .stall_count    (stall_count)
    );

    // Model: history of what entered Execute each cycle, youngest first.
    typedef struct packed {
        logic       v;
        logic       wr;
        logic       ld;
        logic [3:0] rd;
    } ins_t;

    ins_t       hist[$];
    logic [1:0] exp_a, exp_b;
    int         exp_cnt;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic hit(input ins_t p, input logic [3:0] s, input logic u);
        return u && p.v && p.wr && (p.rd == s);
    endfunction

    function automatic logic [1:0] pick(input ins_t e, input ins_t m, input logic [3:0] s, input logic u);
        if (hit(e, s, u) && !e.ld) return 2'b01;
        if (hit(m, s, u))          return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        hist.delete();
        exp_a   = 2'b00;
        exp_b   = 2'b00;
        exp_cnt = 0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_stall_fetch"},  16'(stall_fetch), 16'h0);
        check({tag, "_stall_decode"}, 16'(stall_decode), 16'h0);
        check({tag, "_flush_fd"},     16'(flush_fetchdec), 16'h0);
        check({tag, "_flush_de"},     16'(flush_decex), 16'h0);
        check({tag, "_fwdA"},         16'(fwdA_sel), 16'h0);
        check({tag, "_fwdB"},         16'(fwdB_sel), 16'h0);
        check({tag, "_count"},        16'(stall_count), 16'h0);
    endtask

    // Called just after a rising edge; applies one Decode cycle, checks, advances.
    task automatic step(input logic v, input logic [3:0] r1, input logic u1,
                        input logic [3:0] r2, input logic u2, input logic [3:0] rd,
                        input logic wr, input logic ld, input logic br);
        ins_t e, m, nw;
        logic haz;
        dec_valid = v;  dec_rs1 = r1; dec_rs1_used = u1;
        dec_rs2 = r2;   dec_rs2_used = u2;
        dec_rd = rd;    dec_wr = wr;  dec_load = ld;  branch_taken = br;
        #1;
        e = (hist.size() > 0) ? hist[0] : ins_t'('0);
        m = (hist.size() > 1) ? hist[1] : ins_t'('0);
        haz = v && e.ld && (hit(e, r1, u1) || hit(e, r2, u2));
        check("stall_fetch",    16'(stall_fetch),    16'(haz && !br));
        check("stall_decode",   16'(stall_decode),   16'(haz && !br));
        check("flush_fetchdec", 16'(flush_fetchdec), 16'(br));
        check("flush_decex",    16'(flush_decex),    16'(haz || br));
        check("fwdA_sel",       16'(fwdA_sel),       16'(exp_a));
        check("fwdB_sel",       16'(fwdB_sel),       16'(exp_b));
        check("stall_count",    16'(stall_count),    16'(exp_cnt));
        nw = '0;
        exp_a = 2'b00;
        exp_b = 2'b00;
        if (v && !haz && !br) begin
            nw.v = 1'b1; nw.wr = wr; nw.ld = ld; nw.rd = rd;
            exp_a = pick(e, m, r1, u1);
            exp_b = pick(e, m, r2, u2);
        end
        if (haz && !br && exp_cnt < 7) exp_cnt++;
        hist.push_front(nw);
        if (hist.size() > 2) void'(hist.pop_back());
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rs1_used = 0; dec_rs2_used = 0;
        dec_rd = 0; dec_wr = 0; dec_load = 0; branch_taken = 0;
        model_reset();
        @(posedge clk); #1;
        check_all_zero("reset");
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Dependent ALU op: forward from E.
        step(1, 4'd0, 0, 4'd0, 0, 4'd3, 1, 0, 0);
        step(1, 4'd3, 1, 4'd7, 1, 4'd8, 1, 0, 0);
        check("alu_dep_fwdA", 16'(fwdA_sel), 16'h1);
        check("alu_dep_fwdB", 16'(fwdB_sel), 16'h0);

        // Load-use: one stall cycle, then forward from writeback.
        step(1, 4'd0, 0, 4'd0, 0, 4'd5, 1, 1, 0);
        step(1, 4'd0, 0, 4'd5, 1, 4'd9, 1, 0, 0);
        step(1, 4'd0, 0, 4'd5, 1, 4'd9, 1, 0, 0);
        check("load_use_fwdB",  16'(fwdB_sel), 16'h2);
        check("load_use_count", 16'(stall_count), 16'h1);

        // Distance 2 forwards from M; distance 3 reads the register file.
        step(1, 4'd0, 0, 4'd0, 0, 4'd2, 1, 0, 0);
        step(1, 4'd0, 0, 4'd0, 0, 4'd10, 1, 0, 0);
        step(1, 4'd2, 1, 4'd2, 1, 4'd12, 1, 0, 0);
        check("dist2_fwdA", 16'(fwdA_sel), 16'h2);
        check("dist2_fwdB", 16'(fwdB_sel), 16'h2);
        step(1, 4'd0, 0, 4'd0, 0, 4'd2, 1, 0, 0);
        step(1, 4'd0, 0, 4'd0, 0, 4'd10, 1, 0, 0);
        step(1, 4'd0, 0, 4'd0, 0, 4'd11, 1, 0, 0);
        step(1, 4'd2, 1, 4'd2, 1, 4'd12, 1, 0, 0);
        check("dist3_fwdA", 16'(fwdA_sel), 16'h0);
        check("dist3_fwdB", 16'(fwdB_sel), 16'h0);

        // Double match: youngest producer wins.
        step(1, 4'd0, 0, 4'd0, 0, 4'd4, 1, 0, 0);
        step(1, 4'd0, 0, 4'd0, 0, 4'd4, 1, 0, 0);
        step(1, 4'd4, 1, 4'd0, 0, 4'd13, 1, 0, 0);
        check("double_fwdA", 16'(fwdA_sel), 16'h1);

        // Branch in the same cycle as a load-use hazard.
        step(1, 4'd0, 0, 4'd0, 0, 4'd6, 1, 1, 0);
        step(1, 4'd6, 1, 4'd0, 0, 4'd13, 1, 0, 1);
        check("branch_fwdA",  16'(fwdA_sel), 16'h0);
        check("branch_fwdB",  16'(fwdB_sel), 16'h0);
        check("branch_count", 16'(stall_count), 16'h1);

        // Drive the counter into saturation.
        for (int i = 0; i < 8; i++) begin
            step(1, 4'd0, 0, 4'd0, 0, 4'd1, 1, 1, 0);
            step(1, 4'd1, 1, 4'd0, 0, 4'd13, 1, 0, 0);
            step(1, 4'd1, 1, 4'd0, 0, 4'd13, 1, 0, 0);
        end
        check("sat_count", 16'(stall_count), 16'h7);

        // Reset with a load in E and a stalling consumer in Decode.
        step(1, 4'd0, 0, 4'd0, 0, 4'd11, 1, 1, 0);
        dec_valid = 1; dec_rs1 = 4'd11; dec_rs1_used = 1; dec_rs2_used = 0;
        dec_rd = 4'd14; dec_wr = 1; dec_load = 0; branch_taken = 0;
        #1;
        check("pre_reset_stall", 16'(stall_fetch), 16'h1);
        rst = 1'b0;
        #1;
        check_all_zero("mid_reset");
        model_reset();
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;
        step(1, 4'd11, 1, 4'd0, 0, 4'd14, 1, 0, 0);
        check("post_reset_fwdA", 16'(fwdA_sel), 16'h0);

        // Random traffic over a small register window to provoke hazards.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 9) != 0),
                 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 3)), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
